// File: rtl/timer_ctl_if.sv
// Front-panel / counter signal bundle for timer_ctl.
// Combinational wires only; adds no latency.
// No backpressure; every strobe is a single-cycle event.
interface timer_ctl_if;
    logic        btn_start;
    logic        btn_clear;
    logic        btn_up;
    logic        btn_down;
    logic        btn_mode;
    logic        complete;
    logic [15:0] time_reading;
    logic        init_regs;
    logic        count_enabled;
    logic        inc;
    logic        dec;
    logic        min;
    logic        alarm_led;
    logic [1:0]  state_dbg;

    // Controller side: consumes buttons and counter status, issues counter commands.
    modport master (
        input  btn_start, btn_clear, btn_up, btn_down, btn_mode, complete, time_reading,
        output init_regs, count_enabled, inc, dec, min, alarm_led, state_dbg
    );

    // Panel/counter side: drives buttons and status, receives commands.
    modport slave (
        output btn_start, btn_clear, btn_up, btn_down, btn_mode, complete, time_reading,
        input  init_regs, count_enabled, inc, dec, min, alarm_led, state_dbg
    );
endinterface

// File: rtl/timer_ctl.sv
// Front-panel FSM driving countdown-counter strobes (SET/RUN/PAUSE/ALARM); AUTO_REPEAT_EN adds held-button repeat.
// Latency: outputs registered, respond 2 cycles after a button level rises (1 edge register + 1 output register).
// No backpressure: strobes are single-cycle fire-and-forget; lower-priority same-cycle presses are dropped.
module timer_ctl #(
    parameter int unsigned CLK_FREQ      = 100000000,
    parameter int unsigned ALARM_SEC     = 5,
    parameter int unsigned BLINK_HZ      = 2
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = CLK_FREQ / 2,
    parameter int unsigned REPEAT_PERIOD = CLK_FREQ / 10
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_ctl_if.master  ctl_if
);

    typedef enum logic [1:0] {
        SET   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int unsigned HALF_CYC  = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned ALARM_CYC = ALARM_SEC * CLK_FREQ;
    localparam int          HALF_W    = ($clog2(HALF_CYC) > 0) ? $clog2(HALF_CYC) : 1;
    localparam int          ALARM_W   = ($clog2(ALARM_CYC) > 0) ? $clog2(ALARM_CYC) : 1;

    // Button bit order: 0 start, 1 clear, 2 up, 3 down, 4 mode.
    logic [4:0]         btn_cur_q;
    logic [4:0]         btn_prev_q;
    logic [4:0]         press;
    logic               press_start, press_clear, press_up, press_down, press_mode;
    logic               time_zero, time_max;

    state_t             state_q;
    logic               init_q, cen_q, inc_q, dec_q, min_q, led_q;
    logic [ALARM_W-1:0] alarm_cnt_q;
    logic [HALF_W-1:0]  blink_cnt_q;

    // Register button levels and their previous value for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_cur_q  <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_cur_q  <= {ctl_if.btn_mode, ctl_if.btn_down, ctl_if.btn_up,
                           ctl_if.btn_clear, ctl_if.btn_start};
            btn_prev_q <= btn_cur_q;
        end
    end

    assign press       = btn_cur_q & ~btn_prev_q;
    assign press_start = press[0];
    assign press_clear = press[1];
    assign press_up    = press[2];
    assign press_down  = press[3];
    assign press_mode  = press[4];
    assign time_zero   = (ctl_if.time_reading == 16'h0000);
    assign time_max    = (ctl_if.time_reading == 16'h5959);

`ifdef AUTO_REPEAT_EN
    localparam int unsigned HOLD_MAX = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int          HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_dir_q, hold_dir_d;
    logic              held_up, held_dn, in_edit, rep, rep_up, rep_dn;

    assign held_up = btn_cur_q[2] & ~btn_cur_q[3];
    assign held_dn = btn_cur_q[3] & ~btn_cur_q[2];
    assign in_edit = (state_q == SET) || (state_q == PAUSE);

    // Hold counter: runs while exactly one of up/down is held in an edit state; after
    // reaching REPEAT_DELAY it folds back by REPEAT_PERIOD so repeats recur periodically.
    always_comb begin
        hold_d     = '0;
        hold_dir_d = held_dn;
        rep        = 1'b0;
        if (in_edit && (held_up || held_dn) && !press_start && !press_clear &&
            ((hold_q == '0) || (hold_dir_q == held_dn))) begin
            if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                hold_d = HOLD_W'(REPEAT_DELAY);
                rep    = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
                rep    = (hold_q == HOLD_W'(REPEAT_DELAY - 1));
            end
        end
        rep_up = rep & held_up;
        rep_dn = rep & held_dn;
    end

    // Hold counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_dir_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_dir_q <= hold_dir_d;
        end
    end
`endif

    // Main control FSM with registered command outputs; priority clear > start > mode > up/down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SET;
            init_q      <= 1'b1;
            cen_q       <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            min_q       <= 1'b0;
            led_q       <= 1'b0;
            alarm_cnt_q <= '0;
            blink_cnt_q <= '0;
        end else begin
            init_q <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            case (state_q)
                SET, PAUSE: begin
                    cen_q       <= 1'b0;
                    led_q       <= 1'b0;
                    alarm_cnt_q <= '0;
                    blink_cnt_q <= '0;
                    if (press_clear) begin
                        init_q  <= 1'b1;
                        state_q <= SET;
                    end else if (press_start) begin
                        // A start at 00:00 is consumed but has no effect.
                        if (!time_zero) begin
                            state_q <= RUN;
                            cen_q   <= 1'b1;
                        end
                    end else if (press_mode) begin
                        min_q <= ~min_q;
                    end else if (press_up && !press_down) begin
                        if (!time_max) inc_q <= 1'b1;
                    end else if (press_down && !press_up) begin
                        if (!time_zero) dec_q <= 1'b1;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_up) begin
                        if (!time_max) inc_q <= 1'b1;
                    end else if (rep_dn) begin
                        if (!time_zero) dec_q <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    cen_q       <= 1'b1;
                    alarm_cnt_q <= '0;
                    blink_cnt_q <= '0;
                    if (press_clear) begin
                        init_q  <= 1'b1;
                        cen_q   <= 1'b0;
                        state_q <= SET;
                    end else if (ctl_if.complete) begin
                        cen_q   <= 1'b0;
                        led_q   <= 1'b1;
                        state_q <= ALARM;
                    end else if (press_start) begin
                        cen_q   <= 1'b0;
                        state_q <= PAUSE;
                    end
                end
                ALARM: begin
                    cen_q <= 1'b0;
                    if (press_clear || press_start) begin
                        init_q      <= press_clear;
                        led_q       <= 1'b0;
                        alarm_cnt_q <= '0;
                        blink_cnt_q <= '0;
                        state_q     <= SET;
                    end else if (alarm_cnt_q == ALARM_W'(ALARM_CYC - 1)) begin
                        led_q       <= 1'b0;
                        alarm_cnt_q <= '0;
                        blink_cnt_q <= '0;
                        state_q     <= SET;
                    end else begin
                        alarm_cnt_q <= alarm_cnt_q + 1'b1;
                        if (blink_cnt_q == HALF_W'(HALF_CYC - 1)) begin
                            blink_cnt_q <= '0;
                            led_q       <= ~led_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ctl_if.init_regs     = init_q;
    assign ctl_if.count_enabled = cen_q;
    assign ctl_if.inc           = inc_q;
    assign ctl_if.dec           = dec_q;
    assign ctl_if.min           = min_q;
    assign ctl_if.alarm_led     = led_q;
    assign ctl_if.state_dbg     = state_q;

endmodule

// File: tb/tb_timer_ctl.sv
// Directed testbench for timer_ctl with small timing parameters.
// Inputs driven and outputs sampled on the falling clock edge.
// The counter is stood in for by hand-set time_reading/complete values.
module tb_timer_ctl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [4:0] B_START = 5'b00001;
    localparam logic [4:0] B_CLEAR = 5'b00010;
    localparam logic [4:0] B_UP    = 5'b00100;
    localparam logic [4:0] B_DOWN  = 5'b01000;
    localparam logic [4:0] B_MODE  = 5'b10000;

    timer_ctl_if u_if ();

    timer_ctl #(
        .CLK_FREQ     (20),
        .ALARM_SEC    (5),
        .BLINK_HZ     (2)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4)
`endif
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctl_if (u_if)
    );

    always #5 clk = ~clk;

    task automatic set_btns(input logic [4:0] b);
        u_if.btn_start = b[0];
        u_if.btn_clear = b[1];
        u_if.btn_up    = b[2];
        u_if.btn_down  = b[3];
        u_if.btn_mode  = b[4];
    endtask

    // Raise the given buttons for one edge, release, and return at the negedge where
    // the resulting registered outputs are visible.
    task automatic press_btns(input logic [4:0] b);
        set_btns(b);
        @(negedge clk);
        set_btns(5'b0);
        @(negedge clk);
    endtask

    task automatic test_reset;
        set_btns(5'b0);
        u_if.complete     = 1'b0;
        u_if.time_reading = 16'h0000;
        repeat (2) @(negedge clk);
        n_cmp++; if (u_if.init_regs !== 1'b1) begin n_err++; $display("FAIL rst_init got %b exp 1", u_if.init_regs); end
        n_cmp++; if (u_if.state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", u_if.state_dbg); end
        n_cmp++; if (u_if.count_enabled !== 1'b0) begin n_err++; $display("FAIL rst_cen got %b exp 0", u_if.count_enabled); end
        n_cmp++; if (u_if.min !== 1'b0) begin n_err++; $display("FAIL rst_min got %b exp 0", u_if.min); end
        n_cmp++; if ({u_if.inc, u_if.dec, u_if.alarm_led} !== 3'b000) begin n_err++; $display("FAIL rst_strobes got %b exp 000", {u_if.inc, u_if.dec, u_if.alarm_led}); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (u_if.init_regs !== 1'b1) begin n_err++; $display("FAIL rel_init_hold got %b exp 1", u_if.init_regs); end
        @(negedge clk);
        n_cmp++; if (u_if.init_regs !== 1'b0) begin n_err++; $display("FAIL rel_init_drop got %b exp 0", u_if.init_regs); end
        n_cmp++; if (u_if.state_dbg !== 2'd0) begin n_err++; $display("FAIL rel_state got %0d exp 0", u_if.state_dbg); end
    endtask

    task automatic test_set_run_alarm;
        for (int i = 1; i <= 3; i++) begin
            press_btns(B_UP);
            n_cmp++; if (u_if.inc !== 1'b1) begin n_err++; $display("FAIL set_inc%0d got %b exp 1", i, u_if.inc); end
            u_if.time_reading = 16'(i);
        end
        @(negedge clk);
        n_cmp++; if (u_if.inc !== 1'b0) begin n_err++; $display("FAIL inc_one_cycle got %b exp 0", u_if.inc); end
        press_btns(B_START);
        n_cmp++; if (u_if.state_dbg !== 2'd1) begin n_err++; $display("FAIL run_state got %0d exp 1", u_if.state_dbg); end
        n_cmp++; if (u_if.count_enabled !== 1'b1) begin n_err++; $display("FAIL run_cen got %b exp 1", u_if.count_enabled); end
        u_if.complete = 1'b1;
        @(negedge clk);
        u_if.complete = 1'b0;
        u_if.time_reading = 16'h0000;
        n_cmp++; if (u_if.state_dbg !== 2'd3) begin n_err++; $display("FAIL alarm_state got %0d exp 3", u_if.state_dbg); end
        n_cmp++; if (u_if.count_enabled !== 1'b0) begin n_err++; $display("FAIL alarm_cen got %b exp 0", u_if.count_enabled); end
        n_cmp++; if (u_if.alarm_led !== 1'b1) begin n_err++; $display("FAIL alarm_led_entry got %b exp 1", u_if.alarm_led); end
        // Half-period is 20/(2*2)=5 cycles; alarm lasts 5*20=100 cycles.
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            n_cmp++; if (u_if.state_dbg !== 2'd3) begin n_err++; $display("FAIL alarm_hold k=%0d got %0d exp 3", k, u_if.state_dbg); end
            n_cmp++; if (u_if.alarm_led !== (((k / 5) % 2) == 0)) begin n_err++; $display("FAIL alarm_blink k=%0d got %b exp %b", k, u_if.alarm_led, (((k / 5) % 2) == 0)); end
        end
        @(negedge clk);
        n_cmp++; if (u_if.state_dbg !== 2'd0) begin n_err++; $display("FAIL alarm_timeout_state got %0d exp 0", u_if.state_dbg); end
        n_cmp++; if (u_if.alarm_led !== 1'b0) begin n_err++; $display("FAIL alarm_timeout_led got %b exp 0", u_if.alarm_led); end
    endtask

    task automatic test_boundaries;
        u_if.time_reading = 16'h0000;
        press_btns(B_DOWN);
        n_cmp++; if (u_if.dec !== 1'b0) begin n_err++; $display("FAIL dec_at_zero got %b exp 0", u_if.dec); end
        press_btns(B_START);
        n_cmp++; if (u_if.state_dbg !== 2'd0) begin n_err++; $display("FAIL start_at_zero got %0d exp 0", u_if.state_dbg); end
        press_btns(B_DOWN | B_START);
        n_cmp++; if ({u_if.dec, u_if.state_dbg} !== 3'b000) begin n_err++; $display("FAIL down_start_zero got %b exp 000", {u_if.dec, u_if.state_dbg}); end
        u_if.time_reading = 16'h5959;
        press_btns(B_UP);
        n_cmp++; if (u_if.inc !== 1'b0) begin n_err++; $display("FAIL inc_at_max got %b exp 0", u_if.inc); end
        press_btns(B_DOWN);
        n_cmp++; if (u_if.dec !== 1'b1) begin n_err++; $display("FAIL dec_at_max got %b exp 1", u_if.dec); end
        u_if.time_reading = 16'h0100;
        press_btns(B_UP | B_DOWN);
        n_cmp++; if ({u_if.inc, u_if.dec} !== 2'b00) begin n_err++; $display("FAIL up_down_same got %b exp 00", {u_if.inc, u_if.dec}); end
    endtask

    task automatic test_pause_mode;
        u_if.time_reading = 16'h0010;
        press_btns(B_START);
        n_cmp++; if (u_if.state_dbg !== 2'd1) begin n_err++; $display("FAIL pm_run got %0d exp 1", u_if.state_dbg); end
        press_btns(B_UP);
        n_cmp++; if (u_if.inc !== 1'b0) begin n_err++; $display("FAIL pm_up_in_run got %b exp 0", u_if.inc); end
        press_btns(B_START);
        n_cmp++; if (u_if.state_dbg !== 2'd2) begin n_err++; $display("FAIL pm_pause got %0d exp 2", u_if.state_dbg); end
        n_cmp++; if (u_if.count_enabled !== 1'b0) begin n_err++; $display("FAIL pm_pause_cen got %b exp 0", u_if.count_enabled); end
        press_btns(B_MODE);
        n_cmp++; if (u_if.min !== 1'b1) begin n_err++; $display("FAIL pm_mode got %b exp 1", u_if.min); end
        press_btns(B_UP);
        n_cmp++; if ({u_if.inc, u_if.min, u_if.state_dbg} !== 4'b1110) begin n_err++; $display("FAIL pm_inc_min got %b exp 1110", {u_if.inc, u_if.min, u_if.state_dbg}); end
        press_btns(B_CLEAR | B_START);
        n_cmp++; if ({u_if.init_regs, u_if.state_dbg, u_if.count_enabled} !== 4'b1000) begin n_err++; $display("FAIL pm_clear_start got %b exp 1000", {u_if.init_regs, u_if.state_dbg, u_if.count_enabled}); end
        @(negedge clk);
        n_cmp++; if ({u_if.init_regs, u_if.min} !== 2'b01) begin n_err++; $display("FAIL pm_after_clear got %b exp 01", {u_if.init_regs, u_if.min}); end
    endtask

    task automatic test_alarm_early;
        u_if.time_reading = 16'h0005;
        press_btns(B_START);
        u_if.complete = 1'b1;
        @(negedge clk);
        u_if.complete = 1'b0;
        n_cmp++; if (u_if.state_dbg !== 2'd3) begin n_err++; $display("FAIL ae_alarm got %0d exp 3", u_if.state_dbg); end
        press_btns(B_CLEAR);
        n_cmp++; if ({u_if.init_regs, u_if.state_dbg, u_if.alarm_led} !== 4'b1000) begin n_err++; $display("FAIL ae_clear got %b exp 1000", {u_if.init_regs, u_if.state_dbg, u_if.alarm_led}); end
    endtask

    task automatic test_reset_mid_strobe;
        u_if.time_reading = 16'h0100;
        press_btns(B_MODE);
        set_btns(B_UP);
        @(negedge clk);
        set_btns(5'b0);
        @(posedge clk);
        #1;
        n_cmp++; if (u_if.inc !== 1'b1) begin n_err++; $display("FAIL mid_inc got %b exp 1", u_if.inc); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({u_if.inc, u_if.init_regs, u_if.min, u_if.state_dbg} !== 5'b01000) begin n_err++; $display("FAIL mid_reset got %b exp 01000", {u_if.inc, u_if.init_regs, u_if.min, u_if.state_dbg}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (u_if.init_regs !== 1'b0) begin n_err++; $display("FAIL mid_release got %b exp 0", u_if.init_regs); end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat;
        int cnt = 0;
        int late = 0;
        int first_rep = 0;
        u_if.time_reading = 16'h0100;
        set_btns(B_UP);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 20) set_btns(5'b0);
            if (u_if.inc === 1'b1) begin
                cnt++;
                if (i >= 22) late++;
                if (cnt == 2) first_rep = i;
            end
        end
        n_cmp++; if (cnt !== 5) begin n_err++; $display("FAIL rep_count got %0d exp 5", cnt); end
        n_cmp++; if (first_rep !== 9) begin n_err++; $display("FAIL rep_first got %0d exp 9", first_rep); end
        n_cmp++; if (late !== 0) begin n_err++; $display("FAIL rep_after_release got %0d exp 0", late); end
    endtask
`endif

    initial begin
        test_reset();
        test_set_run_alarm();
        test_boundaries();
        test_pause_mode();
        test_alarm_early();
        test_reset_mid_strobe();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_ctl.md
Name: timer_ctl

Overview:
Front-panel control FSM that sits directly upstream of the countdown counter. It turns debounced button levels into the counter's command strobes: init_regs, count_enabled, inc, dec and min. It consumes the counter's complete flag and time_reading to sequence set, run, pause and alarm phases, and drives an alarm LED.

Parameters:
CLK_FREQ, 100000000, clock frequency in Hz.
ALARM_SEC, 5, alarm duration in seconds before automatic return to SET.
BLINK_HZ, 2, alarm LED blink rate; half-period = CLK_FREQ/(2*BLINK_HZ) cycles.
REPEAT_DELAY, CLK_FREQ/2, hold cycles before auto-repeat begins.
REPEAT_PERIOD, CLK_FREQ/10, cycles between auto-repeat strobes.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
btn_start  in  1  debounced level; press toggles run/pause.
btn_clear  in  1  debounced level; press zeroes the counter.
btn_up  in  1  debounced level; increment selected field.
btn_down  in  1  debounced level; decrement selected field.
btn_mode  in  1  debounced level; press toggles the minutes/seconds field select.
complete  in  1  counter reached 00:00 while counting (registered in the counter).
time_reading  in  16  counter BCD value {tens_min, min, tens_sec, sec}.
init_regs  out  1  counter synchronous clear.
count_enabled  out  1  counter run enable.
inc  out  1  one-cycle increment strobe.
dec  out  1  one-cycle decrement strobe.
min  out  1  field select; 1 = minutes, 0 = seconds.
alarm_led  out  1  blinking alarm indicator.
state_dbg  out  2  current FSM state encoding.

Behaviour:
- Reset (rst_n=0): state=SET, init_regs=1, count_enabled=0, inc=0, dec=0, min=0, alarm_led=0, all timers and edge registers cleared. init_regs drops on the first clk edge after release.
- Each btn_* is registered once. press = cur & ~prev, so a press is a 1-cycle event delayed 1 cycle after the level rises. All outputs are registered, so an output responds 2 cycles after the input edge.
- States: SET=0, RUN=1, PAUSE=2, ALARM=3.
- Priority within one cycle is clear > start > mode > up/down. Only the highest-priority event is acted on; the others are dropped.
- SET and PAUSE:
  - clear press → init_regs=1 for 1 cycle; next state SET.
  - start press → RUN, but only if time_reading≠0; otherwise ignored.
  - mode press → min toggles.
  - up press → inc=1 for 1 cycle, suppressed when time_reading=16'h5959.
  - down press → dec=1 for 1 cycle, suppressed when time_reading=0.
  - up and down pressed in the same cycle → neither strobe.
- RUN:
  - count_enabled=1, inc=dec=0; up/down/mode ignored.
  - start press → PAUSE, and count_enabled drops.
  - clear press → init_regs pulse, next state SET.
  - complete=1 → ALARM, and count_enabled drops the next cycle. complete takes priority over a same-cycle start press.
- ALARM:
  - count_enabled=0; alarm_led toggles every blink half-period, starting at 1 on entry.
  - After ALARM_SEC*CLK_FREQ cycles → SET, alarm_led=0.
  - Any start or clear press ends ALARM early. Clear also pulses init_regs.
- min holds its value across all states; only a mode press in SET/PAUSE or reset changes it.
- Timer counters are sized with $clog2 of their maxima. They reset to 0 on every state entry. There is no wrap beyond their terminal count.
- Asynchronous reset asserted in any state, including mid-strobe, forces the reset values immediately. A partially emitted strobe is not completed.

Optional Feature:
AUTO_REPEAT_EN.
- Defined: in SET/PAUSE, when btn_up or btn_down is held alone, a hold counter runs. After REPEAT_DELAY cycles it emits one inc/dec strobe, then one every REPEAT_PERIOD cycles, subject to the same 59:59 / 00:00 suppression. Release, the other button, or a state change clears the hold counter.
- Undefined: one strobe per press only, and no hold counter is synthesised.

Test Plan:
- Reset release → init_regs=1 through the first edge then 0; state_dbg=0; min=0; count_enabled=0.
- Set 00:03: press up 3 times, then start → count_enabled=1, state_dbg=1. After complete=1 → state_dbg=3 and count_enabled=0 within 1 cycle.
- ALARM with CLK_FREQ=20, BLINK_HZ=2, ALARM_SEC=5 → alarm_led toggles every 5 cycles; state returns to SET after 100 cycles; alarm_led=0.
- time_reading=0, press down and start → no dec, state stays SET. With time_reading=16'h5959, press up → no inc.
- RUN, then start press → PAUSE. Mode press → min=1; up press → single inc with min=1. Clear and start pressed together → init_regs pulse only, state SET.
- AUTO_REPEAT_EN with REPEAT_DELAY=8, REPEAT_PERIOD=4, btn_up held for 20 cycles → one press strobe, then strobes at hold counts 8, 12, 16, 20, and none after release.
